// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: state encodings,
// blank segment pattern and the active-low hex-to-7-segment table.
package disp_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segments {g,f,e,d,c,b,a}, active-low; element k holds the pattern for hex value k.
    localparam logic [15:0][6:0] SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/disp_scan_ctrl_hex7seg.sv
// Combinational 4-bit hex value to active-low 7-segment decoder.
module hex7seg
    import disp_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TBL[hex];
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed display scan controller with blanking gap between digits.
// Optional per-slot brightness (PWM on the anode) when DISP_SCAN_BRIGHT_EN is defined.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int DIG_W     = 2,
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 64,
    localparam int N_DIG    = 2 ** DIG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [4*N_DIG-1:0] digits,
    input  logic [N_DIG-1:0]   dp,
`ifdef DISP_SCAN_BRIGHT_EN
    input  logic [3:0]         bright,
`endif
    output logic [N_DIG-1:0]   an,
    output logic [6:0]         seg,
    output logic               dp_o,
    output logic [DIG_W-1:0]   idx
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIG_W-1:0]   idx_d;
    logic [4:0]         snap_q, snap_d;
    logic               load;
    logic [6:0]         dec_seg;
    logic [N_DIG-1:0]   an_d;
    logic [6:0]         seg_d;
    logic               dp_d;
    logic               lit;

`ifdef DISP_SCAN_BRIGHT_EN
    logic [3:0]         bright_q, bright_d;
    logic [31:0]        on_cyc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx     <= '0;
            snap_q  <= '0;
            an      <= '1;
            seg     <= SEG_OFF;
            dp_o    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx     <= idx_d;
            snap_q  <= snap_d;
            an      <= an_d;
            seg     <= seg_d;
            dp_o    <= dp_d;
        end
    end

`ifdef DISP_SCAN_BRIGHT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_q <= '0;
        end else begin
            bright_q <= bright_d;
        end
    end
`endif

    // Next state, counter and digit index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx;
        load    = 1'b0;
        if (en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx + DIG_W'(1);
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Snapshot of the upcoming digit, taken only on BLANK entry
    always_comb begin
        snap_d = snap_q;
        if (load) begin
            snap_d = {dp[idx_d], digits[int'(idx_d) * 4 +: 4]};
        end
    end

    // Decoder sits on the snapshot's D side so seg registers on the same edge as the snapshot.
    hex7seg u_hex7seg (
        .hex (snap_d[3:0]),
        .seg (dec_seg)
    );

`ifdef DISP_SCAN_BRIGHT_EN
    always_comb begin
        bright_d = load ? bright : bright_q;
        on_cyc   = ((32'(bright_d) + 32'd1) * 32'(SHOW_CYC)) >> 4;
        lit      = (32'(cnt_d) < on_cyc);
    end
`else
    always_comb begin
        lit = 1'b1;
    end
`endif

    // Registered outputs follow the next state so they change on the same edge
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d != IDLE) begin
            seg_d = dec_seg;
            dp_d  = ~snap_d[4];
            if (state_d == SHOW && lit) begin
                an_d[idx_d] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl (DIG_W=2, SHOW_CYC=4, BLANK_CYC=2).
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
`ifdef DISP_SCAN_BRIGHT_EN
    logic [3:0]  bright;
`endif
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_o;
    logic [1:0]  idx;

    int tests = 0;
    int fails = 0;

    // Hand-computed expectations for digits=16'h3A71, dp=4'b0100
    logic [6:0] exp_seg [4] = '{7'h79, 7'h78, 7'h08, 7'h30};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    disp_scan_ctrl #(
        .DIG_W     (2),
        .SHOW_CYC  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .digits (digits),
        .dp     (dp),
`ifdef DISP_SCAN_BRIGHT_EN
        .bright (bright),
`endif
        .an     (an),
        .seg    (seg),
        .dp_o   (dp_o),
        .idx    (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full digit slot: 2 BLANK cycles then 4 SHOW cycles
    task automatic slot(input int i);
        for (int b = 0; b < 2; b++) begin
            step();
            chk("blank_an", 32'(an), 32'hF);
            chk("blank_idx", 32'(idx), 32'(i));
            chk("blank_seg", 32'(seg), 32'(exp_seg[i]));
            chk("blank_dp", 32'(dp_o), 32'(exp_dp[i]));
        end
        for (int s = 0; s < 4; s++) begin
            step();
            chk("show_an", 32'(an), 32'(exp_an[i]));
            chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
            chk("show_seg", 32'(seg), 32'(exp_seg[i]));
            chk("show_idx", 32'(idx), 32'(i));
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        digits = 16'h3A71;
        dp     = 4'b0100;
`ifdef DISP_SCAN_BRIGHT_EN
        bright = 4'hF;
`endif
        step();
        step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp_o), 32'd1);
        chk("rst_idx", 32'(idx), 32'd0);

        // Basic scan and wrap over 9 slots, then slot for idx 1
        rst = 1'b0;
        en  = 1'b0;
        for (int k = 0; k < 10; k++) slot(k % 4);

        // Disable on SHOW cycle 3 of idx 2
        step(); step();
        chk("d_blank_an", 32'(an), 32'hF);
        chk("d_blank_idx", 32'(idx), 32'd2);
        step(); step(); step();
        chk("d_show_an", 32'(an), 32'hB);
        en = 1'b1;
        step();
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_idx", 32'(idx), 32'd0);
        chk("dis_seg", 32'(seg), 32'h7F);
        chk("dis_dp", 32'(dp_o), 32'd1);
        step();
        chk("idle_an", 32'(an), 32'hF);
        en = 1'b0;
        step();
        chk("re_blank0_an", 32'(an), 32'hF);
        chk("re_blank0_seg", 32'(seg), 32'h79);
        step();
        chk("re_blank1_an", 32'(an), 32'hF);
        step();
        chk("re_show_an", 32'(an), 32'hE);

        // Digit 0 changes 1 -> 8 during its SHOW; visible only at next idx-0 BLANK
        digits = 16'h3A78;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("hold_seg", 32'(seg), 32'h79);
            chk("hold_an", 32'(an), 32'hE);
        end
        slot(1);
        slot(2);
        slot(3);
        step();
        chk("new_seg", 32'(seg), 32'h00);
        chk("new_an", 32'(an), 32'hF);
        step();
        step();
        chk("new_show_an", 32'(an), 32'hE);
        chk("new_show_seg", 32'(seg), 32'h00);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp_o), 32'd1);
        chk("arst_idx", 32'(idx), 32'd0);
        step();
        chk("rst_hold_an", 32'(an), 32'hF);
        rst = 1'b0;
        step();
        chk("post_rst_an", 32'(an), 32'hF);
        chk("post_rst_seg", 32'(seg), 32'h00);
        chk("post_rst_idx", 32'(idx), 32'd0);
        step();
        step();
        chk("post_rst_show", 32'(an), 32'hE);

`ifdef DISP_SCAN_BRIGHT_EN
        // bright=3 with SHOW_CYC=4: ((3+1)*4)>>4 = 1 lit cycle
        bright = 4'd3;
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        step();
        step();
        chk("br3_c0", 32'(an), 32'hE);
        step();
        chk("br3_c1", 32'(an), 32'hF);
        step();
        chk("br3_c2", 32'(an), 32'hF);
        step();
        chk("br3_c3", 32'(an), 32'hF);
        step();
        chk("br3_blank_idx", 32'(idx), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
